// File: rtl/vga_timing_out12.sv
// VGA timing generator on the 7x pixel clock: divide-by-7 pixel strobe, beam
// counters, blank-gated colour and registered sync/blank/colour to the DAC.
module vga_timing_out12 #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        rst,
  input  logic        clk7x,
  input  logic [3:0]  ri,
  input  logic [3:0]  gi,
  input  logic [3:0]  bi,
  output logic [3:0]  ro,
  output logic [3:0]  go,
  output logic [3:0]  bo,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        pix_ce,
  output logic [11:0] hctr,
  output logic [11:0] vctr,
  output logic        frame_start
);

  localparam int unsigned CW     = 12;
  localparam int unsigned HTOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(HTOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VTOT - 1);
  localparam logic [2:0]    PH_LAST = 3'd6;

  if (HTOT > 4096 || VTOT > 4096) begin : g_bad_totals
    $error("vga_timing_out12: HTOT/VTOT exceed 12-bit counter range");
  end

  logic [2:0]    r_phase;
  logic [CW-1:0] r_hctr;
  logic [CW-1:0] r_vctr;
  logic [3:0]    r_ro;
  logic [3:0]    r_go;
  logic [3:0]    r_bo;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank;
  logic          r_frame_start;

  logic [2:0]    w_phase_nxt;
  logic [CW-1:0] w_hctr_nxt;
  logic [CW-1:0] w_vctr_nxt;
  logic          w_pix_ce;
  logic          w_active;
  logic          w_hs_on;
  logic          w_vs_on;
  logic [31:0]   w_hx;
  logic [31:0]   w_vx;

  assign w_pix_ce = (r_phase == PH_LAST);
  assign w_hx     = 32'(r_hctr);
  assign w_vx     = 32'(r_vctr);

  // Next beam position; phase, column and line may all wrap on one edge.
  always_comb begin
    w_phase_nxt = r_phase + 3'd1;
    w_hctr_nxt  = r_hctr;
    w_vctr_nxt  = r_vctr;
    if (w_pix_ce) begin
      w_phase_nxt = 3'd0;
      if (r_hctr == H_LAST) begin
        w_hctr_nxt = '0;
        w_vctr_nxt = (r_vctr == V_LAST) ? '0 : r_vctr + CW'(1);
      end else begin
        w_hctr_nxt = r_hctr + CW'(1);
      end
    end
  end

  always_comb begin
    w_active = 1'b0;
    w_hs_on  = 1'b0;
    w_vs_on  = 1'b0;
    w_active = (w_hx < H_ACTIVE) && (w_vx < V_ACTIVE);
    w_hs_on  = (w_hx >= HS_BEG) && (w_hx < HS_END);
    w_vs_on  = (w_vx >= VS_BEG) && (w_vx < VS_END);
  end

  always_ff @(posedge clk7x) begin
    if (rst) begin
      r_phase <= '0;
      r_hctr  <= '0;
      r_vctr  <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_hctr  <= w_hctr_nxt;
      r_vctr  <= w_vctr_nxt;
    end
  end

  // Colour is sampled every clk7x so sub-pixel dither reaches the DAC intact.
  always_ff @(posedge clk7x) begin
    if (rst) begin
      r_ro          <= '0;
      r_go          <= '0;
      r_bo          <= '0;
      r_blank       <= 1'b1;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_ro          <= w_active ? ri : 4'h0;
      r_go          <= w_active ? gi : 4'h0;
      r_bo          <= w_active ? bi : 4'h0;
      r_blank       <= ~w_active;
      r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
      r_frame_start <= (r_phase == 3'd0) && (r_hctr == '0) && (r_vctr == '0);
    end
  end

  assign ro          = r_ro;
  assign go          = r_go;
  assign bo          = r_bo;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign pix_ce      = w_pix_ce;
  assign hctr        = r_hctr;
  assign vctr        = r_vctr;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_out12.sv
// Directed bench for vga_timing_out12 on a 15x7 pixel frame (735 clk7x per frame).
module tb_vga_timing_out12;

  logic        rst;
  logic        clk7x;
  logic [3:0]  ri, gi, bi;
  logic [3:0]  ro, go, bo;
  logic        hsync, vsync, blank, pix_ce, frame_start;
  logic [11:0] hctr, vctr;

  int errors = 0;
  int checks = 0;

  vga_timing_out12 #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .rst(rst), .clk7x(clk7x),
    .ri(ri), .gi(gi), .bi(bi),
    .ro(ro), .go(go), .bo(bo),
    .hsync(hsync), .vsync(vsync), .blank(blank), .pix_ce(pix_ce),
    .hctr(hctr), .vctr(vctr), .frame_start(frame_start)
  );

  initial clk7x = 1'b0;
  always #5 clk7x = ~clk7x;

  task automatic tick();
    @(posedge clk7x);
    #1;
  endtask

  // After this, the next tick is edge 1 after release.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ri = 4'hA; gi = 4'h5; bi = 4'hF;
    tick(); tick(); tick();
    checks++; if (hctr !== 12'd0) begin errors++; $display("FAIL reset_hctr got=%0d exp=0", hctr); end
    checks++; if (vctr !== 12'd0) begin errors++; $display("FAIL reset_vctr got=%0d exp=0", vctr); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", blank); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    checks++; if ({ro, go, bo} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", {ro, go, bo}); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (pix_ce !== 1'b0) begin errors++; $display("FAIL reset_pix_ce got=%b exp=0", pix_ce); end
  endtask

  task automatic test_pix_ce();
    int first = -1, last = 0, cnt = 0, gap_bad = 0;
    int fs_cnt = 0, fs_first = -1, fs_second = -1;
    do_reset();
    for (int n = 1; n <= 1500; n++) begin
      tick();
      if (pix_ce === 1'b1) begin
        if (first < 0) first = n;
        else if (n - last != 7) gap_bad++;
        last = n;
        cnt++;
      end
      if (frame_start === 1'b1) begin
        if (fs_cnt == 0) fs_first = n;
        if (fs_cnt == 1) fs_second = n;
        fs_cnt++;
      end
    end
    checks++; if (first != 6) begin errors++; $display("FAIL pix_first got=%0d exp=6", first); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL pix_gap got=%0d bad gaps exp=0", gap_bad); end
    checks++; if (cnt != 214) begin errors++; $display("FAIL pix_count got=%0d exp=214", cnt); end
    checks++; if (fs_cnt != 3) begin errors++; $display("FAIL fs_count got=%0d exp=3", fs_cnt); end
    checks++; if (fs_first != 1) begin errors++; $display("FAIL fs_first got=%0d exp=1", fs_first); end
    checks++; if (fs_second != 736) begin errors++; $display("FAIL fs_second got=%0d exp=736", fs_second); end
  endtask

  task automatic test_colour_sync();
    int act_cnt = 0, run = 0, maxrun = 0, blank_cnt = 0, leak = 0, late_vis = 0, junk = 0;
    int brun = 0, brun_bad = 0;
    int hs_cnt = 0, hs_first = -1, hs_run = 0, hs_maxrun = 0;
    int vs_cnt = 0, vs_first = -1;
    logic act;
    ri = 4'hA; gi = 4'h5; bi = 4'hF;
    do_reset();
    for (int n = 1; n <= 735; n++) begin
      tick();
      act = (ro === 4'hA) && (go === 4'h5) && (bo === 4'hF) && (blank === 1'b0);
      if (act) begin
        if (brun > 0 && brun != 49) brun_bad++;
        brun = 0;
        act_cnt++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (blank === 1'b1) begin
        blank_cnt++; brun++;
        if ({ro, go, bo} !== 12'h000) leak++;
      end else if (!act) junk++;
      if (n > 420 && blank !== 1'b1) late_vis++;
      if (hsync === 1'b0) begin
        if (hs_first < 0) hs_first = n;
        hs_cnt++; hs_run++;
        if (hs_run > hs_maxrun) hs_maxrun = hs_run;
      end else hs_run = 0;
      if (vsync === 1'b0) begin
        if (vs_first < 0) vs_first = n;
        vs_cnt++;
      end
    end
    checks++; if (act_cnt != 224) begin errors++; $display("FAIL active_count got=%0d exp=224", act_cnt); end
    checks++; if (maxrun != 56) begin errors++; $display("FAIL active_run got=%0d exp=56", maxrun); end
    checks++; if (brun_bad != 0) begin errors++; $display("FAIL hblank_run got=%0d bad runs exp=0", brun_bad); end
    checks++; if (blank_cnt != 511) begin errors++; $display("FAIL blank_count got=%0d exp=511", blank_cnt); end
    checks++; if (leak != 0) begin errors++; $display("FAIL blank_leak got=%0d exp=0", leak); end
    checks++; if (junk != 0) begin errors++; $display("FAIL active_colour got=%0d wrong cycles exp=0", junk); end
    checks++; if (late_vis != 0) begin errors++; $display("FAIL vblank_lines got=%0d visible exp=0", late_vis); end
    checks++; if (hs_cnt != 147) begin errors++; $display("FAIL hsync_count got=%0d exp=147", hs_cnt); end
    checks++; if (hs_first != 71) begin errors++; $display("FAIL hsync_first got=%0d exp=71", hs_first); end
    checks++; if (hs_maxrun != 21) begin errors++; $display("FAIL hsync_width got=%0d exp=21", hs_maxrun); end
    checks++; if (vs_cnt != 105) begin errors++; $display("FAIL vsync_count got=%0d exp=105", vs_cnt); end
    checks++; if (vs_first != 526) begin errors++; $display("FAIL vsync_first got=%0d exp=526", vs_first); end
  endtask

  task automatic test_toggle();
    logic [3:0] val;
    ri = 4'h3; gi = 4'h0; bi = 4'h0;
    do_reset();
    for (int n = 1; n <= 20; n++) tick();
    for (int i = 0; i < 14; i++) begin
      val = (i % 2 == 0) ? 4'h3 : 4'h4;
      ri = val;
      tick();
      checks++;
      if (ro !== val) begin errors++; $display("FAIL toggle_ro step=%0d got=%h exp=%h", i, ro, val); end
    end
    ri = 4'hA; gi = 4'h5; bi = 4'hF;
  endtask

  task automatic test_mid_reset();
    int pfirst = -1, pcnt = 0, ffirst = -1, fcnt = 0, hfirst = -1;
    do_reset();
    for (int n = 1; n <= 612; n++) tick();
    checks++; if (hctr !== 12'd12 || vctr !== 12'd5) begin errors++; $display("FAIL mid_pos got=%0d,%0d exp=12,5", hctr, vctr); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL mid_sync got=%b%b exp=00", hsync, vsync); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (hctr !== 12'd0 || vctr !== 12'd0) begin errors++; $display("FAIL mid_rst_ctr got=%0d,%0d exp=0,0", hctr, vctr); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL mid_rst_sync got=%b%b exp=11", hsync, vsync); end
    checks++; if (blank !== 1'b1 || ro !== 4'h0) begin errors++; $display("FAIL mid_rst_out got blank=%b ro=%h exp blank=1 ro=0", blank, ro); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_rst_fs got=%b exp=0", frame_start); end
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (pix_ce === 1'b1) begin if (pfirst < 0) pfirst = n; pcnt++; end
      if (frame_start === 1'b1) begin if (ffirst < 0) ffirst = n; fcnt++; end
      if (hsync === 1'b0 && hfirst < 0) hfirst = n;
    end
    checks++; if (pfirst != 6 || pcnt != 11) begin errors++; $display("FAIL restart_pix got first=%0d cnt=%0d exp 6,11", pfirst, pcnt); end
    checks++; if (ffirst != 1 || fcnt != 1) begin errors++; $display("FAIL restart_fs got first=%0d cnt=%0d exp 1,1", ffirst, fcnt); end
    checks++; if (hfirst != 71) begin errors++; $display("FAIL restart_hsync got=%0d exp=71", hfirst); end
  endtask

  task automatic test_wrap();
    int vmax = 0;
    do_reset();
    for (int n = 1; n <= 734; n++) begin
      tick();
      if (int'(vctr) > vmax) vmax = int'(vctr);
    end
    checks++; if (vmax != 6) begin errors++; $display("FAIL wrap_vmax got=%0d exp=6", vmax); end
    checks++; if (hctr !== 12'd14 || vctr !== 12'd6 || pix_ce !== 1'b1) begin
      errors++; $display("FAIL wrap_pre got h=%0d v=%0d ce=%b exp 14,6,1", hctr, vctr, pix_ce); end
    tick();
    checks++; if (hctr !== 12'd0 || vctr !== 12'd0 || pix_ce !== 1'b0) begin
      errors++; $display("FAIL wrap_post got h=%0d v=%0d ce=%b exp 0,0,0", hctr, vctr, pix_ce); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL wrap_fs_early got=%b exp=0", frame_start); end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap_fs got=%b exp=1", frame_start); end
    checks++; if (hctr !== 12'd0 || vctr !== 12'd0) begin errors++; $display("FAIL wrap_hold got h=%0d v=%0d exp 0,0", hctr, vctr); end
  endtask

  initial begin
    rst = 1'b1;
    ri = 4'h0; gi = 4'h0; bi = 4'h0;
    test_reset();
    test_pix_ce();
    test_colour_sync();
    test_toggle();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
